// File: rtl/rc4_keystream_decryptor.sv
// RC4 PRGA stage: walks i/j over the shuffled S RAM, XORs each keystream byte with the
// encrypted ROM into the decrypted RAM, and can abort early on non-text plaintext.
module rc4_keystream_decryptor #(
    parameter int unsigned RAM_WIDTH      = 8,
    parameter int unsigned RAM_LENGTH     = 8,
    parameter int unsigned MESSAGE_LENGTH = 32,
    parameter int unsigned MSG_ADDR_WIDTH = 5,
    parameter bit          CHECK_TEXT     = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      finished,
    output logic                      invalid,
    input  logic [RAM_WIDTH-1:0]      s_ram_out,
    output logic [RAM_LENGTH-1:0]     s_address,
    output logic [RAM_WIDTH-1:0]      s_ram_in,
    output logic                      s_write_enable,
    input  logic [RAM_WIDTH-1:0]      enc_rom_out,
    output logic [MSG_ADDR_WIDTH-1:0] enc_address,
    output logic [MSG_ADDR_WIDTH-1:0] dec_address,
    output logic [RAM_WIDTH-1:0]      dec_ram_in,
    output logic                      dec_write_enable,
    output logic [MSG_ADDR_WIDTH-1:0] kTap,
    output logic [7:0]                iTap,
    output logic [7:0]                jTap,
    output logic [3:0]                stateTap
);

    typedef enum logic [3:0] {
        StAwaitStart,
        StIncI,
        StWaitSi,
        StReadSi,
        StWaitSj,
        StReadSj,
        StWriteJ,
        StAddrF,
        StWaitF,
        StReadF,
        StWriteDec
    } state_e;

    localparam logic [MSG_ADDR_WIDTH-1:0] KLast   = MSG_ADDR_WIDTH'(MESSAGE_LENGTH - 1);
    localparam logic [RAM_WIDTH-1:0]      ChSpace = RAM_WIDTH'(32'h20);
    localparam logic [RAM_WIDTH-1:0]      ChLowA  = RAM_WIDTH'(32'h61);
    localparam logic [RAM_WIDTH-1:0]      ChLowZ  = RAM_WIDTH'(32'h7A);

    state_e                    state_q, state_d;
    logic                      start_q, start_prev_q;
    logic [RAM_LENGTH-1:0]     i_q, i_d, j_q, j_d;
    logic [MSG_ADDR_WIDTH-1:0] k_q, k_d;
    logic [RAM_WIDTH-1:0]      si_q, si_d, sj_q, sj_d, p_q, p_d;
    logic                      invalid_q, invalid_d, finished_q, finished_d;
    logic [RAM_LENGTH-1:0]     s_address_q, s_address_d;
    logic [RAM_WIDTH-1:0]      s_ram_in_q, s_ram_in_d;
    logic                      s_we_q, s_we_d;
    logic [MSG_ADDR_WIDTH-1:0] enc_address_q, enc_address_d;
    logic [MSG_ADDR_WIDTH-1:0] dec_address_q, dec_address_d;
    logic [RAM_WIDTH-1:0]      dec_ram_in_q, dec_ram_in_d;
    logic                      dec_we_q, dec_we_d;
    logic                      start_edge;
    logic                      p_is_text;

    // Start is registered twice so a level held high yields a single edge.
    assign start_edge = start_q & ~start_prev_q;
    assign p_is_text  = (p_q == ChSpace) || ((p_q >= ChLowA) && (p_q <= ChLowZ));

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        si_d          = si_q;
        sj_d          = sj_q;
        p_d           = p_q;
        invalid_d     = invalid_q;
        finished_d    = 1'b0;
        s_address_d   = s_address_q;
        s_ram_in_d    = s_ram_in_q;
        s_we_d        = 1'b0;
        enc_address_d = enc_address_q;
        dec_address_d = dec_address_q;
        dec_ram_in_d  = dec_ram_in_q;
        dec_we_d      = 1'b0;

        unique case (state_q)
            StAwaitStart: begin
                if (start_edge) begin
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    invalid_d = 1'b0;
                    state_d   = StIncI;
                end
            end
            StIncI: begin
                i_d           = i_q + RAM_LENGTH'(1);
                s_address_d   = i_q + RAM_LENGTH'(1);
                enc_address_d = k_q;
                state_d       = StWaitSi;
            end
            StWaitSi: state_d = StReadSi;
            StReadSi: begin
                si_d        = s_ram_out;
                j_d         = j_q + RAM_LENGTH'(s_ram_out);
                s_address_d = j_q + RAM_LENGTH'(s_ram_out);
                state_d     = StWaitSj;
            end
            StWaitSj: state_d = StReadSj;
            StReadSj: begin
                sj_d        = s_ram_out;
                s_address_d = i_q;
                s_ram_in_d  = s_ram_out;
                s_we_d      = 1'b1;
                state_d     = StWriteJ;
            end
            StWriteJ: begin
                s_address_d = j_q;
                s_ram_in_d  = si_q;
                s_we_d      = 1'b1;
                state_d     = StAddrF;
            end
            StAddrF: begin
                s_address_d = RAM_LENGTH'(si_q + sj_q);
                state_d     = StWaitF;
            end
            StWaitF: state_d = StReadF;
            StReadF: begin
                p_d     = s_ram_out ^ enc_rom_out;
                state_d = StWriteDec;
            end
            StWriteDec: begin
                if (CHECK_TEXT && !p_is_text) begin
                    invalid_d  = 1'b1;
                    finished_d = 1'b1;
                    state_d    = StAwaitStart;
                end else begin
                    dec_address_d = k_q;
                    dec_ram_in_d  = p_q;
                    dec_we_d      = 1'b1;
                    if (k_q == KLast) begin
                        finished_d = 1'b1;
                        state_d    = StAwaitStart;
                    end else begin
                        k_d     = k_q + MSG_ADDR_WIDTH'(1);
                        state_d = StIncI;
                    end
                end
            end
            default: state_d = StAwaitStart;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StAwaitStart;
            start_q       <= 1'b0;
            start_prev_q  <= 1'b0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            si_q          <= '0;
            sj_q          <= '0;
            p_q           <= '0;
            invalid_q     <= 1'b0;
            finished_q    <= 1'b0;
            s_address_q   <= '0;
            s_ram_in_q    <= '0;
            s_we_q        <= 1'b0;
            enc_address_q <= '0;
            dec_address_q <= '0;
            dec_ram_in_q  <= '0;
            dec_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            start_prev_q  <= start_q;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            p_q           <= p_d;
            invalid_q     <= invalid_d;
            finished_q    <= finished_d;
            s_address_q   <= s_address_d;
            s_ram_in_q    <= s_ram_in_d;
            s_we_q        <= s_we_d;
            enc_address_q <= enc_address_d;
            dec_address_q <= dec_address_d;
            dec_ram_in_q  <= dec_ram_in_d;
            dec_we_q      <= dec_we_d;
        end
    end

    assign finished         = finished_q;
    assign invalid          = invalid_q;
    assign s_address        = s_address_q;
    assign s_ram_in         = s_ram_in_q;
    assign s_write_enable   = s_we_q;
    assign enc_address      = enc_address_q;
    assign dec_address      = dec_address_q;
    assign dec_ram_in       = dec_ram_in_q;
    assign dec_write_enable = dec_we_q;
    assign kTap             = k_q;
    assign iTap             = 8'(i_q);
    assign jTap             = 8'(j_q);
    assign stateTap         = state_q;

endmodule

// File: tb/tb_rc4_keystream_decryptor.sv
// Scoreboard bench: two decryptor instances (3-byte checked, 32-byte unchecked) with
// behavioural S RAM / ROM / output RAM and a software RC4 reference.
module tb_rc4_keystream_decryptor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    // Instance A: MESSAGE_LENGTH=3, CHECK_TEXT=1
    logic       rst_a, start_a, fin_a, inv_a, s_we_a, dec_we_a;
    logic [7:0] s_out_a, s_addr_a, s_in_a, enc_out_a, dec_in_a, itap_a, jtap_a;
    logic [4:0] enc_addr_a, dec_addr_a, ktap_a;
    logic [3:0] st_a;
    // Instance B: MESSAGE_LENGTH=32, CHECK_TEXT=0
    logic       rst_b, start_b, fin_b, inv_b, s_we_b, dec_we_b;
    logic [7:0] s_out_b, s_addr_b, s_in_b, enc_out_b, dec_in_b, itap_b, jtap_b;
    logic [4:0] enc_addr_b, dec_addr_b, ktap_b;
    logic [3:0] st_b;

    rc4_keystream_decryptor #(
        .RAM_WIDTH(8), .RAM_LENGTH(8), .MESSAGE_LENGTH(3), .MSG_ADDR_WIDTH(5), .CHECK_TEXT(1'b1)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .start(start_a), .finished(fin_a), .invalid(inv_a),
        .s_ram_out(s_out_a), .s_address(s_addr_a), .s_ram_in(s_in_a), .s_write_enable(s_we_a),
        .enc_rom_out(enc_out_a), .enc_address(enc_addr_a), .dec_address(dec_addr_a),
        .dec_ram_in(dec_in_a), .dec_write_enable(dec_we_a), .kTap(ktap_a), .iTap(itap_a),
        .jTap(jtap_a), .stateTap(st_a)
    );

    rc4_keystream_decryptor #(
        .RAM_WIDTH(8), .RAM_LENGTH(8), .MESSAGE_LENGTH(32), .MSG_ADDR_WIDTH(5), .CHECK_TEXT(1'b0)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .start(start_b), .finished(fin_b), .invalid(inv_b),
        .s_ram_out(s_out_b), .s_address(s_addr_b), .s_ram_in(s_in_b), .s_write_enable(s_we_b),
        .enc_rom_out(enc_out_b), .enc_address(enc_addr_b), .dec_address(dec_addr_b),
        .dec_ram_in(dec_in_b), .dec_write_enable(dec_we_b), .kTap(ktap_b), .iTap(itap_b),
        .jTap(jtap_b), .stateTap(st_b)
    );

    // Memories: synchronous read, write captured on the clock edge; load copies the preload image.
    logic [7:0] s_mem_a[256], pre_a[256], enc_a[32], dec_a[32];
    logic [7:0] s_mem_b[256], pre_b[256], enc_b[32], dec_b[32];
    logic       load;

    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) s_mem_a[x] <= pre_a[x];
            for (int x = 0; x < 32; x++) dec_a[x] <= 8'hEE;
        end else begin
            if (s_we_a) s_mem_a[s_addr_a] <= s_in_a;
            if (dec_we_a) dec_a[dec_addr_a] <= dec_in_a;
        end
        s_out_a   <= s_mem_a[s_addr_a];
        enc_out_a <= enc_a[enc_addr_a];
    end

    always @(posedge clk) begin
        if (load) begin
            for (int x = 0; x < 256; x++) s_mem_b[x] <= pre_b[x];
            for (int x = 0; x < 32; x++) dec_b[x] <= 8'hEE;
        end else begin
            if (s_we_b) s_mem_b[s_addr_b] <= s_in_b;
            if (dec_we_b) dec_b[dec_addr_b] <= dec_in_b;
        end
        s_out_b   <= s_mem_b[s_addr_b];
        enc_out_b <= enc_b[enc_addr_b];
    end

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_a[$];
    wr_t exp_b[$];
    wr_t sb_a, sb_b;
    int  fin_cnt_a;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: every decrypted-RAM write is popped against the expected queue.
    always @(negedge clk) begin
        if (fin_a) fin_cnt_a++;
        if (dec_we_a) begin
            tests++;
            if (exp_a.size() == 0) begin
                fails++;
                $display("FAIL dec_a write: got addr %0d data %0h, required no write",
                         dec_addr_a, dec_in_a);
            end else begin
                sb_a = exp_a.pop_front();
                if (dec_addr_a !== sb_a.addr || dec_in_a !== sb_a.data) begin
                    fails++;
                    $display("FAIL dec_a write: got addr %0d data %0h, required addr %0d data %0h",
                             dec_addr_a, dec_in_a, sb_a.addr, sb_a.data);
                end
            end
        end
        if (dec_we_b) begin
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL dec_b write: got addr %0d data %0h, required no write",
                         dec_addr_b, dec_in_b);
            end else begin
                sb_b = exp_b.pop_front();
                if (dec_addr_b !== sb_b.addr || dec_in_b !== sb_b.data) begin
                    fails++;
                    $display("FAIL dec_b write: got addr %0d data %0h, required addr %0d data %0h",
                             dec_addr_b, dec_in_b, sb_b.addr, sb_b.data);
                end
            end
        end
    end

    // Software RC4 PRGA over ms[]; leaves the final permutation in ms[].
    logic [7:0] ms[256];
    logic [7:0] ks_m[32];

    task automatic rc4_model(input int n);
        logic [7:0] mi, mj, t, fi;
        mi = 8'd0;
        mj = 8'd0;
        for (int q = 0; q < n; q++) begin
            mi     = mi + 8'd1;
            mj     = mj + ms[mi];
            t      = ms[mi];
            ms[mi] = ms[mj];
            ms[mj] = t;
            fi     = ms[mi] + ms[mj];
            ks_m[q] = ms[fi];
        end
    endtask

    task automatic push_exp(input int sel, input logic [4:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        if (sel == 0) exp_a.push_back(w);
        else exp_b.push_back(w);
    endtask

    task automatic load_mems();
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic ident_a();
        for (int x = 0; x < 256; x++) pre_a[x] = 8'(x);
    endtask

    task automatic set_enc_a(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        enc_a[0] = e0;
        enc_a[1] = e1;
        enc_a[2] = e2;
    endtask

    // Start pulse, then count falling edges until finished is seen; also checks pulse width.
    task automatic run_dut(input int sel, input int budget, output int cyc);
        if (sel == 0) start_a = 1'b1;
        else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = 1;
        while (((sel == 0) ? fin_a : fin_b) == 1'b0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("finished seen", (sel == 0) ? fin_a : fin_b, 1);
        @(negedge clk);
        chk("finished one cycle wide", (sel == 0) ? fin_a : fin_b, 0);
    endtask

    task automatic check_s1_state();
        chk("s[1] unchanged", s_mem_a[1], 8'h01);
        chk("s[2]", s_mem_a[2], 8'h03);
        chk("s[3]", s_mem_a[3], 8'h05);
        chk("s[5]", s_mem_a[5], 8'h02);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         c0;
        int         w;
        int         diffs;
        logic [7:0] key[3];
        logic [7:0] kj, t;

        tests = 0;
        fails = 0;
        fin_cnt_a = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        load = 1'b0;
        ident_a();
        for (int x = 0; x < 256; x++) pre_b[x] = 8'(x);
        for (int x = 0; x < 32; x++) begin
            enc_a[x] = 8'h00;
            enc_b[x] = 8'h00;
        end
        load_mems();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst finished", fin_a, 0);
        chk("rst invalid", inv_a, 0);
        chk("rst s_we", s_we_a, 0);
        chk("rst dec_we", dec_we_a, 0);
        chk("rst s_address", s_addr_a, 0);
        chk("rst enc_address", enc_addr_a, 0);
        chk("rst state", st_a, 0);
        chk("rst taps", {ktap_a, itap_a, jtap_a}, 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        // 1: identity S, keystream 2,5,7
        set_enc_a(8'h63, 8'h64, 8'h66);
        load_mems();
        for (int q = 0; q < 3; q++) push_exp(0, 5'(q), 8'h61);
        run_dut(0, 60, cyc);
        chk("s1 latency", cyc, 32);
        chk("s1 invalid", inv_a, 0);
        check_s1_state();
        chk("s1 queue drained", exp_a.size(), 0);

        // 2: byte 1 decodes to 0x05 -> abort
        set_enc_a(8'h63, 8'h00, 8'h66);
        load_mems();
        push_exp(0, 5'd0, 8'h61);
        run_dut(0, 60, cyc);
        chk("s2 abort latency", cyc, 22);
        chk("s2 invalid", inv_a, 1);
        chk("s2 dec[1] untouched", dec_a[1], 8'hEE);
        chk("s2 dec[2] untouched", dec_a[2], 8'hEE);
        chk("s2 queue drained", exp_a.size(), 0);
        repeat (5) @(negedge clk);
        chk("s2 invalid held", inv_a, 1);

        // 2b: same bytes with checking off, full 32-byte run
        enc_b[0] = 8'h63;
        enc_b[1] = 8'h00;
        enc_b[2] = 8'h66;
        for (int x = 3; x < 32; x++) enc_b[x] = 8'($urandom_range(0, 255));
        for (int x = 0; x < 256; x++) ms[x] = pre_b[x];
        rc4_model(32);
        for (int q = 0; q < 32; q++) push_exp(1, 5'(q), enc_b[q] ^ ks_m[q]);
        load_mems();
        run_dut(1, 400, cyc);
        chk("s2b latency", cyc, 322);
        chk("s2b invalid", inv_b, 0);
        chk("s2b dec[1]", dec_b[1], 8'h05);
        chk("s2b dec[2]", dec_b[2], 8'h61);
        chk("s2b queue drained", exp_b.size(), 0);

        // 3: start held high for 100 cycles -> one run; invalid cleared
        set_enc_a(8'h63, 8'h64, 8'h66);
        load_mems();
        for (int q = 0; q < 3; q++) push_exp(0, 5'(q), 8'h61);
        c0 = fin_cnt_a;
        start_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("s3 invalid cleared", inv_a, 0);
        repeat (98) @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        chk("s3 one finished pulse", fin_cnt_a - c0, 1);
        chk("s3 queue drained", exp_a.size(), 0);
        load_mems();
        for (int q = 0; q < 3; q++) push_exp(0, 5'(q), 8'h61);
        run_dut(0, 60, cyc);
        chk("s3 second run latency", cyc, 32);
        chk("s3 second run invalid", inv_a, 0);

        // 4: reset during WRITE_J of byte 1, then a clean rerun
        load_mems();
        push_exp(0, 5'd0, 8'h61);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        w = 0;
        while (!(ktap_a == 5'd1 && s_we_a) && w < 60) begin
            @(negedge clk);
            w++;
        end
        chk("s4 reached byte1 write_j", {ktap_a, s_we_a}, {5'd1, 1'b1});
        rst_a = 1'b1;
        @(negedge clk);
        chk("s4 state idle", st_a, 0);
        chk("s4 enables low", {s_we_a, dec_we_a}, 0);
        chk("s4 finished low", fin_a, 0);
        rst_a = 1'b0;
        @(negedge clk);
        chk("s4 dec[1] untouched", dec_a[1], 8'hEE);
        chk("s4 queue drained", exp_a.size(), 0);
        load_mems();
        for (int q = 0; q < 3; q++) push_exp(0, 5'(q), 8'h61);
        run_dut(0, 60, cyc);
        chk("s4 rerun latency", cyc, 32);
        check_s1_state();

        // 5: s[1]=0 gives i==j at byte 1; S around that swap stays put
        ident_a();
        pre_a[1] = 8'h00;
        set_enc_a(8'h61, 8'h66, 8'h6B);
        for (int x = 0; x < 256; x++) ms[x] = pre_a[x];
        rc4_model(3);
        for (int q = 0; q < 3; q++) push_exp(0, 5'(q), enc_a[q] ^ ks_m[q]);
        load_mems();
        run_dut(0, 60, cyc);
        chk("s5 latency", cyc, 32);
        chk("s5 invalid", inv_a, 0);
        chk("s5 dec[2]", dec_a[2], 8'h63);
        chk("s5 s[0..2]", {s_mem_a[0], s_mem_a[1], s_mem_a[2]}, 24'h000002);
        chk("s5 s[3],s[5]", {s_mem_a[3], s_mem_a[5]}, 16'h0503);
        diffs = 0;
        for (int x = 0; x < 256; x++) if (s_mem_a[x] !== ms[x]) diffs++;
        chk("s5 S matches model", diffs, 0);
        chk("s5 queue drained", exp_a.size(), 0);
        ident_a();

        // 6: KSA-scheduled S, random 32-byte message
        for (int x = 0; x < 3; x++) key[x] = 8'($urandom_range(0, 255));
        for (int x = 0; x < 256; x++) pre_b[x] = 8'(x);
        kj = 8'd0;
        for (int x = 0; x < 256; x++) begin
            kj = kj + pre_b[x] + key[x % 3];
            t = pre_b[x];
            pre_b[x] = pre_b[kj];
            pre_b[kj] = t;
        end
        for (int x = 0; x < 32; x++) enc_b[x] = 8'($urandom_range(0, 255));
        for (int x = 0; x < 256; x++) ms[x] = pre_b[x];
        rc4_model(32);
        for (int q = 0; q < 32; q++) push_exp(1, 5'(q), enc_b[q] ^ ks_m[q]);
        load_mems();
        run_dut(1, 400, cyc);
        chk("s6 latency", cyc, 322);
        diffs = 0;
        for (int x = 0; x < 256; x++) if (s_mem_b[x] !== ms[x]) diffs++;
        chk("s6 S matches model", diffs, 0);
        chk("s6 queue drained", exp_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
